// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// State encoding, end-of-program marker and default release delay.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FILL,
        HOLD,
        RUN
    } state_t;

    localparam logic [31:0] END_MARKER  = 32'h0;
    localparam int          REL_DLY_DEF = 2;

endpackage

// File: rtl/instr_mem_loader.sv
// Streams a program image into IM while holding the CPU in reset, then releases it.
// Build option: define ZERO_FILL_EN to zero the words past the image before release.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int CNT_W   = $clog2(DEPTH) + 1,
    parameter int REL_DLY = REL_DLY_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [31:0]      s_data_i,
    input  logic             s_last_i,
    output logic             im_we_o,
    output logic [31:0]      im_addr_o,
    output logic [31:0]      im_wdata_o,
    output logic             cpu_rst_n_o,
    output logic             done_o,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic             err_ovf_o
);

    localparam int               HW        = $clog2(REL_DLY + 1) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(REL_DLY - 1);

    state_t           state_q;
    state_t           state_d;
    state_t           after_load;
    logic [CNT_W-1:0] cnt_q;
    logic [HW-1:0]    hold_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             err_q;
    logic             full;
    logic             hs;
    logic             end_hs;
`ifdef ZERO_FILL_EN
    logic [CNT_W-1:0] fill_q;
`endif

    assign full   = (cnt_q == DEPTH_C);
    assign hs     = s_valid_i & s_ready_o;
    assign end_hs = hs & (s_last_i | (s_data_i == END_MARKER));

`ifdef ZERO_FILL_EN
    assign after_load = (cnt_q + CNT_W'(1) < DEPTH_C) ? FILL : HOLD;
`else
    assign after_load = HOLD;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = IDLE;
            LOAD: begin
                if (end_hs) begin
                    state_d = after_load;
                end else if (full) begin
                    // The full cycle already carries the final write pulse.
                    state_d = (REL_DLY > 1) ? HOLD : RUN;
                end
            end
`ifdef ZERO_FILL_EN
            FILL: begin
                if (fill_q == DEPTH_C - CNT_W'(1)) begin
                    state_d = HOLD;
                end
            end
`else
            FILL: state_d = HOLD;
`endif
            HOLD: begin
                if (hold_q >= HOLD_LAST) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (start_i) begin
            state_d = LOAD;
        end
    end

    always_comb begin
        s_ready_o   = (state_q == LOAD) && !full && !start_i;
        done_o      = (state_q == RUN);
        cpu_rst_n_o = (state_q == RUN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            hold_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
`ifdef ZERO_FILL_EN
            fill_q  <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            if (start_i) begin
                cnt_q  <= '0;
                err_q  <= 1'b0;
                hold_q <= '0;
            end else begin
                case (state_q)
                    LOAD: begin
                        hold_q <= full ? HW'(1) : '0;
                        if (hs) begin
                            we_q    <= 1'b1;
                            addr_q  <= 32'(cnt_q) << 2;
                            wdata_q <= s_data_i;
                            cnt_q   <= cnt_q + CNT_W'(1);
`ifdef ZERO_FILL_EN
                            fill_q  <= cnt_q + CNT_W'(1);
`endif
                        end
                        if (full && s_valid_i) begin
                            err_q <= 1'b1;
                        end
                    end
`ifdef ZERO_FILL_EN
                    FILL: begin
                        we_q    <= 1'b1;
                        addr_q  <= 32'(fill_q) << 2;
                        wdata_q <= END_MARKER;
                        fill_q  <= fill_q + CNT_W'(1);
                    end
`endif
                    HOLD:    hold_q <= hold_q + HW'(1);
                    default: ;
                endcase
            end
        end
    end

    assign im_we_o    = we_q;
    assign im_addr_o  = addr_q;
    assign im_wdata_o = wdata_q;
    assign word_cnt_o = cnt_q;
    assign err_ovf_o  = err_q;

endmodule
